// File: rtl/sya_out_wb_arb_if.sv
// Signal bundle around the output write-back arbiter: job configuration and
// status, the per-bank de-skewed input streams, and the global-buffer write port.
interface sya_out_wb_arb_if #(
    parameter int unsigned NUM_BANK   = 4,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 16
);
    localparam int unsigned BANK_W = $clog2(NUM_BANK);

    logic                           cfg_start;
    logic [ADDR_WIDTH-1:0]          cfg_base_addr;
    logic [15:0]                    cfg_num_pkg;
    logic [NUM_BANK*DATA_WIDTH-1:0] in_data;
    logic [NUM_BANK-1:0]            in_vld;
    logic [NUM_BANK-1:0]            in_rdy;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [BANK_W-1:0]              wr_bank;
    logic                           wr_vld;
    logic                           wr_rdy;
    logic                           busy;
    logic                           done;

    // Arbiter side
    modport slave (
        input  cfg_start, cfg_base_addr, cfg_num_pkg, in_data, in_vld, wr_rdy,
        output in_rdy, wr_data, wr_addr, wr_bank, wr_vld, busy, done
    );

    // Environment side (banks, global buffer, controller)
    modport master (
        output cfg_start, cfg_base_addr, cfg_num_pkg, in_data, in_vld, wr_rdy,
        input  in_rdy, wr_data, wr_addr, wr_bank, wr_vld, busy, done
    );
endinterface

// File: rtl/sya_out_wb_arb.sv
// Write-back scheduler for the systolic-array de-skew stage. Grants bank streams
// a whole package at a time, round-robin, onto the single global-buffer write
// port, generating linear addresses from the configured base.
module sya_out_wb_arb #(
    parameter int unsigned NUM_BANK   = 4,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned PKG_LEN    = 16,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    sya_out_wb_arb_if.slave bus
);
    localparam int unsigned BANK_W = $clog2(NUM_BANK);
    localparam int unsigned BEAT_W = $clog2(PKG_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKG_LEN - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           num_pkg_q, num_pkg_d;
    logic [15:0]           pkg_cnt_q, pkg_cnt_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [BANK_W-1:0]     grant_q, grant_d;
    logic [BANK_W-1:0]     last_q, last_d;

    logic                  hit;
    logic [BANK_W-1:0]     hit_bank;
    logic [BANK_W-1:0]     cand;
    logic [16:0]           pkg_next;
    logic                  beat_fire;
    logic [NUM_BANK-1:0]   in_rdy_w;
    logic                  wr_vld_w;

    // Round-robin search: first valid bank strictly after the last grant
    always_comb begin
        hit      = 1'b0;
        hit_bank = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_BANK; i++) begin
            cand = BANK_W'((32'(last_q) + i) % NUM_BANK);
            if (!hit && bus.in_vld[cand]) begin
                hit      = 1'b1;
                hit_bank = cand;
            end
        end
    end

    // Next-state, counters and handshake outputs
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        num_pkg_d  = num_pkg_q;
        pkg_cnt_d  = pkg_cnt_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        last_d     = last_q;
        in_rdy_w   = '0;
        wr_vld_w   = 1'b0;
        beat_fire  = 1'b0;
        pkg_next   = {1'b0, pkg_cnt_q} + 17'd1;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    addr_d    = bus.cfg_base_addr;
                    num_pkg_d = bus.cfg_num_pkg;
                    pkg_cnt_d = '0;
                    state_d   = (bus.cfg_num_pkg == 16'd0) ? ST_DONE : ST_ARB;
                end
            end
            ST_ARB: begin
                if (hit) begin
                    grant_d    = hit_bank;
                    last_d     = hit_bank;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                wr_vld_w          = bus.in_vld[grant_q];
                in_rdy_w[grant_q] = bus.wr_rdy;
                beat_fire         = bus.in_vld[grant_q] & bus.wr_rdy;
                if (beat_fire) begin
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        pkg_cnt_d = pkg_next[15:0];
                        state_d   = (pkg_next == {1'b0, num_pkg_q}) ? ST_DONE : ST_ARB;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            num_pkg_q  <= '0;
            pkg_cnt_q  <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            last_q     <= LAST_BANK;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            num_pkg_q  <= num_pkg_d;
            pkg_cnt_q  <= pkg_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
        end
    end

    assign bus.in_rdy  = in_rdy_w;
    assign bus.wr_vld  = wr_vld_w;
    assign bus.wr_data = bus.in_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    assign bus.wr_addr = addr_q;
    assign bus.wr_bank = grant_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
endmodule
